// File: rtl/vid_sched_pkg.sv
// Shared types for the video UDP TX scheduler: read FSM states, packet tag and header geometry.
package vid_sched_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    HDR       = 3'd2,
    PAY       = 3'd3,
    WAIT_DONE = 3'd4
  } rd_state_t;

  typedef struct packed {
    logic [15:0] frame_id;
    logic [15:0] pkt_idx;
  } pkt_tag_t;

  localparam int HDR_WORDS = 2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/vid_pingpong_ram.sv
// Two-bank packet buffer: one write port, one registered read port, addressed as {bank, word}.
module vid_pingpong_ram #(
  parameter int DEPTH = 960,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          sys_clk,
  input  logic          we,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic          rd_bank,
  input  logic [AW-1:0] rd_addr,
  output logic [15:0]   rd_data
);

  localparam int WORDS = 2 * (1 << AW);

  logic [15:0] mem [0:WORDS-1];

  // Write port and one-cycle registered read port
  always_ff @(posedge sys_clk) begin
    if (we) begin
      mem[{wr_bank, wr_addr}] <= wr_data;
    end
    rd_data <= mem[{rd_bank, rd_addr}];
  end

endmodule

// File: rtl/video_udp_tx_scheduler.sv
// Frame-to-packet scheduler feeding a UDP transmitter from a ping-pong packet buffer.
// Optional header words are enabled by defining VID_SCHED_HDR_EN.
module video_udp_tx_scheduler
  import vid_sched_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int V_ACTIVE = 1080,
  parameter int PKT_PIX  = 960
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        vid_fs,
  input  logic        vid_de,
  input  logic [15:0] vid_data,
  output logic        tx_start,
  output logic [15:0] tx_len,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        tx_done,
  output logic [15:0] drop_cnt,
  output logic        overflow
);

  localparam int AW = (PKT_PIX > 1) ? $clog2(PKT_PIX) : 1;
`ifdef VID_SCHED_HDR_EN
  localparam int N_HDR = HDR_WORDS;
`else
  localparam int N_HDR = 0;
`endif
  localparam int TOTAL = PKT_PIX + N_HDR;
  localparam int CW = $clog2(TOTAL + 1);
  localparam logic [AW-1:0] LAST_PTR  = AW'(PKT_PIX - 1);
  localparam logic [CW-1:0] TOTAL_CNT = CW'(TOTAL);
  localparam logic [15:0]   TX_LEN    = 16'(2 * TOTAL);

  if (((H_ACTIVE % PKT_PIX) != 0) || (V_ACTIVE < 1)) begin : g_bad_geometry
    $error("video_udp_tx_scheduler: H_ACTIVE must be a multiple of PKT_PIX");
  end

  // write side
  logic          fs_d;
  logic          wr_bank;
  logic [AW-1:0] wr_ptr;
  logic          dropping;
  logic [15:0]   frame_id;
  logic [15:0]   pkt_idx;
  pkt_tag_t      tags [2];
  logic [1:0]    bank_full;
  logic          fs_rise, cur_drop, pkt_last, wr_en, fill_set;

  // read side
  rd_state_t     state, next_state;
  logic          rd_bank;
  logic [CW-1:0] issue_cnt;
  logic          pend_valid, pend_hdr;
  logic [15:0]   pend_hdr_data;
  logic          skid_valid;
  logic [15:0]   skid_data;
  logic [15:0]   ram_rd_data, arr_data;
  logic [AW-1:0] rd_addr;
  logic [1:0]    occ_next;
  logic          pop, can_issue, issue, drained, release_bank;
  logic [1:0]    set_vec, clr_vec;
  pkt_tag_t      cur_tag;

  // Write-side decode: a packet is dropped if its target bank was still full at its first pixel
  always_comb begin
    fs_rise = vid_fs & ~fs_d;
    if (wr_ptr == {AW{1'b0}}) begin
      cur_drop = bank_full[wr_bank];
    end else begin
      cur_drop = dropping;
    end
    pkt_last = vid_de & (wr_ptr == LAST_PTR);
    wr_en    = vid_de & ~cur_drop;
    fill_set = pkt_last & ~cur_drop;
  end

  // Pixel capture, packet tagging, drop accounting and frame-edge handling
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      fs_d     <= 1'b0;
      wr_bank  <= 1'b0;
      wr_ptr   <= {AW{1'b0}};
      dropping <= 1'b0;
      frame_id <= 16'd0;
      pkt_idx  <= 16'd0;
      tags[0]  <= '{16'd0, 16'd0};
      tags[1]  <= '{16'd0, 16'd0};
      drop_cnt <= 16'd0;
      overflow <= 1'b0;
    end else begin
      fs_d <= vid_fs;
      if (vid_de) begin
        dropping <= cur_drop;
        if (pkt_last) begin
          wr_ptr  <= {AW{1'b0}};
          pkt_idx <= pkt_idx + 16'd1;
          if (cur_drop) begin
            drop_cnt <= sat_inc16(drop_cnt);
            overflow <= 1'b1;
          end else begin
            tags[wr_bank] <= '{frame_id, pkt_idx};
            wr_bank       <= ~wr_bank;
          end
        end else begin
          wr_ptr <= wr_ptr + AW'(1);
        end
      end
      // Frame edge wins over the packet bookkeeping above, after the bank is committed
      if (fs_rise) begin
        frame_id <= frame_id + 16'd1;
        pkt_idx  <= 16'd0;
        wr_ptr   <= {AW{1'b0}};
      end
    end
  end

  // Bank occupancy: fill and release may land on the same cycle (always different banks)
  always_comb begin
    set_vec = fill_set ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
    clr_vec = release_bank ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
  end

  // Bank full flags
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      bank_full <= 2'b00;
    end else begin
      bank_full <= (bank_full | set_vec) & ~clr_vec;
    end
  end

  vid_pingpong_ram #(.DEPTH(PKT_PIX), .AW(AW)) u_ram (
    .sys_clk (sys_clk),
    .we      (wr_en),
    .wr_bank (wr_bank),
    .wr_addr (wr_ptr),
    .wr_data (vid_data),
    .rd_bank (rd_bank),
    .rd_addr (rd_addr),
    .rd_data (ram_rd_data)
  );

  // Read FSM next state; items are issued only when the output reg plus skid can absorb them
  always_comb begin
    next_state   = state;
    issue        = 1'b0;
    cur_tag      = tags[rd_bank];
    pop          = tx_valid & tx_ready;
    occ_next     = 2'(tx_valid) + 2'(skid_valid) + 2'(pend_valid) - 2'(pop);
    can_issue    = (issue_cnt != TOTAL_CNT) && (occ_next <= 2'd1);
    drained      = (issue_cnt == TOTAL_CNT) && !pend_valid && !skid_valid && (!tx_valid || pop);
    rd_addr      = AW'(issue_cnt - CW'(N_HDR));
    arr_data     = pend_hdr ? pend_hdr_data : ram_rd_data;
    release_bank = (state == WAIT_DONE) && tx_done;
    case (state)
      IDLE: begin
        if (bank_full[rd_bank]) begin
          next_state = START;
        end else begin
          next_state = IDLE;
        end
      end
`ifdef VID_SCHED_HDR_EN
      START: next_state = HDR;
      HDR: begin
        issue = can_issue;
        if (can_issue && (issue_cnt == CW'(HDR_WORDS - 1))) begin
          next_state = PAY;
        end else begin
          next_state = HDR;
        end
      end
`else
      START: next_state = PAY;
`endif
      PAY: begin
        issue = can_issue;
        if (drained) begin
          next_state = WAIT_DONE;
        end else begin
          next_state = PAY;
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          next_state = IDLE;
        end else begin
          next_state = WAIT_DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Read FSM state, handshake outputs, issue pipeline and output/skid registers
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      rd_bank       <= 1'b0;
      issue_cnt     <= {CW{1'b0}};
      pend_valid    <= 1'b0;
      pend_hdr      <= 1'b0;
      pend_hdr_data <= 16'd0;
      skid_valid    <= 1'b0;
      skid_data     <= 16'd0;
      tx_start      <= 1'b0;
      tx_len        <= 16'd0;
      tx_data       <= 16'd0;
      tx_valid      <= 1'b0;
    end else begin
      state    <= next_state;
      tx_start <= (state == IDLE) && (next_state == START);
      if ((state == IDLE) && (next_state == START)) begin
        tx_len <= TX_LEN;
      end else if (release_bank) begin
        tx_len <= 16'd0;
      end
      if (release_bank) begin
        rd_bank <= ~rd_bank;
      end
      if (state == START) begin
        issue_cnt <= {CW{1'b0}};
      end else if (issue) begin
        issue_cnt <= issue_cnt + CW'(1);
      end
      pend_valid    <= issue;
      pend_hdr      <= issue && (state == HDR);
      pend_hdr_data <= (issue_cnt == {CW{1'b0}}) ? cur_tag.frame_id : cur_tag.pkt_idx;
      // Skid always holds the older word, so it refills the output register first
      if (!tx_valid || pop) begin
        if (skid_valid) begin
          tx_valid   <= 1'b1;
          tx_data    <= skid_data;
          skid_valid <= pend_valid;
          skid_data  <= arr_data;
        end else if (pend_valid) begin
          tx_valid <= 1'b1;
          tx_data  <= arr_data;
        end else begin
          tx_valid <= 1'b0;
        end
      end else if (pend_valid) begin
        skid_valid <= 1'b1;
        skid_data  <= arr_data;
      end
    end
  end

endmodule

// File: tb/tb_video_udp_tx_scheduler.sv
// Directed bench for video_udp_tx_scheduler with a small geometry (8-pixel packets).
module tb_video_udp_tx_scheduler;

  localparam int PKT = 8;
`ifdef VID_SCHED_HDR_EN
  localparam int NH = 2;
`else
  localparam int NH = 0;
`endif
  localparam int NW = PKT + NH;
  localparam logic [15:0] EXP_LEN = 16'(2 * NW);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vid_fs = 1'b0;
  logic        vid_de = 1'b0;
  logic [15:0] vid_data = 16'd0;
  logic        tx_start;
  logic [15:0] tx_len;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        tx_done = 1'b0;
  logic [15:0] drop_cnt;
  logic        overflow;

  video_udp_tx_scheduler #(.H_ACTIVE(16), .V_ACTIVE(2), .PKT_PIX(PKT)) dut (
    .sys_clk  (clk),
    .rst_n    (rst_n),
    .vid_fs   (vid_fs),
    .vid_de   (vid_de),
    .vid_data (vid_data),
    .tx_start (tx_start),
    .tx_len   (tx_len),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_done  (tx_done),
    .drop_cnt (drop_cnt),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endfunction

  // receiver model state
  bit          rand_ready = 1'b0;
  bit          hold_done = 1'b0;
  int          n_start = 0;
  int          n_rx = 0;
  int          wcnt = 0;
  bit          in_pkt = 1'b0;
  bit          wait_done = 1'b0;
  int          dcnt = 0;
  int          first_start_cyc = -1;
  int          extra_words = 0;
  bit          stalled_prev = 1'b0;
  logic [15:0] stall_data = 16'd0;
  logic [15:0] cur_h0, cur_h1, cur_first, cur_len;
  bit          cur_contig;
  logic [15:0] rx_h0 [32];
  logic [15:0] rx_h1 [32];
  logic [15:0] rx_first [32];
  logic [15:0] rx_len [32];
  bit          rx_contig [32];

  // Transmitter model: drives tx_ready/tx_done on the falling edge and collects accepted words
  initial begin
    forever begin
      @(negedge clk);
      tx_done  = 1'b0;
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled_prev) begin
        check("stall_valid", n_rx, 32'(tx_valid), 32'd1);
        check("stall_data", n_rx, 32'(tx_data), 32'(stall_data));
      end
      if (tx_start) begin
        n_start++;
        if (n_start == 1) first_start_cyc = cyc;
        in_pkt  = 1'b1;
        wcnt    = 0;
        cur_len = tx_len;
      end
      if (tx_valid && tx_ready) begin
        if (!in_pkt) begin
          extra_words++;
        end else begin
          if (wcnt < NH) begin
            if (wcnt == 0) cur_h0 = tx_data;
            else cur_h1 = tx_data;
          end else if (wcnt == NH) begin
            cur_first  = tx_data;
            cur_contig = 1'b1;
          end else if (tx_data != cur_first + 16'(wcnt - NH)) begin
            cur_contig = 1'b0;
          end
          wcnt++;
          if (wcnt == NW) begin
            if (n_rx < 32) begin
              rx_h0[n_rx]     = cur_h0;
              rx_h1[n_rx]     = cur_h1;
              rx_first[n_rx]  = cur_first;
              rx_len[n_rx]    = cur_len;
              rx_contig[n_rx] = cur_contig;
            end
            n_rx++;
            in_pkt    = 1'b0;
            wait_done = 1'b1;
            dcnt      = 0;
          end
        end
      end
      stalled_prev = tx_valid && !tx_ready;
      stall_data   = tx_data;
      if (wait_done && !hold_done) begin
        dcnt++;
        if (dcnt == 4) begin
          tx_done   = 1'b1;
          wait_done = 1'b0;
        end
      end
    end
  end

  logic [15:0] pix_seq = 16'd0;
  int          last_pix_cyc = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic frame_edge();
    vid_fs = 1'b1;
    tick();
    tick();
    vid_fs = 1'b0;
    tick();
  endtask

  task automatic send_pix(int n, int gap);
    for (int i = 0; i < n; i++) begin
      vid_de       = 1'b1;
      vid_data     = pix_seq;
      last_pix_cyc = cyc;
      pix_seq      = pix_seq + 16'd1;
      tick();
      vid_de = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic wait_rx(int n, int budget);
    int k = 0;
    while (n_rx < n && k < budget) begin
      tick();
      k++;
    end
    check("wait_rx", n, 32'(n_rx >= n), 32'd1);
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, "_tx_start"}, 0, 32'(tx_start), 32'd0);
    check({tag, "_tx_len"}, 0, 32'(tx_len), 32'd0);
    check({tag, "_tx_data"}, 0, 32'(tx_data), 32'd0);
    check({tag, "_tx_valid"}, 0, 32'(tx_valid), 32'd0);
    check({tag, "_drop_cnt"}, 0, 32'(drop_cnt), 32'd0);
    check({tag, "_overflow"}, 0, 32'(overflow), 32'd0);
  endtask

  typedef struct {
    logic [15:0] fid;
    logic [15:0] pid;
    logic [15:0] first;
  } exp_pkt_t;

  localparam int NEXP = 14;
  exp_pkt_t exp_tab [NEXP];
  int lat_ref = 0;

  initial begin
    // expected packets in arrival order: {frame_id, pkt_idx, first pixel value}
    exp_tab[0]  = '{16'd1, 16'd0, 16'd0};
    exp_tab[1]  = '{16'd1, 16'd1, 16'd8};
    exp_tab[2]  = '{16'd1, 16'd2, 16'd16};
    exp_tab[3]  = '{16'd1, 16'd3, 16'd24};
    exp_tab[4]  = '{16'd2, 16'd0, 16'd32};
    exp_tab[5]  = '{16'd2, 16'd1, 16'd40};
    exp_tab[6]  = '{16'd2, 16'd2, 16'd48};
    exp_tab[7]  = '{16'd2, 16'd3, 16'd56};
    exp_tab[8]  = '{16'd3, 16'd0, 16'd64};
    exp_tab[9]  = '{16'd3, 16'd1, 16'd72};
    exp_tab[10] = '{16'd3, 16'd3, 16'd88};
    exp_tab[11] = '{16'd4, 16'd0, 16'd96};
    exp_tab[12] = '{16'd5, 16'd0, 16'd109};
    exp_tab[13] = '{16'd1, 16'd0, 16'd125};

    tick();
    tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    // 1: one frame, tx_ready held high
    frame_edge();
    send_pix(PKT, 3);
    lat_ref = last_pix_cyc;
    send_pix(3 * PKT, 3);
    wait_rx(4, 400);
    check("start_latency", 0, 32'(first_start_cyc - lat_ref), 32'd2);
    check("drop_after_t1", 0, 32'(drop_cnt), 32'd0);
    check("ovf_after_t1", 0, 32'(overflow), 32'd0);

    // 2: random backpressure
    rand_ready = 1'b1;
    frame_edge();
    send_pix(4 * PKT, 6);
    wait_rx(8, 600);
    rand_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // 3: withhold tx_done so the third packet lands on a full bank
    hold_done = 1'b1;
    frame_edge();
    send_pix(3 * PKT, 1);
    for (int i = 0; i < 4; i++) tick();
    check("drop_after_t3", 0, 32'(drop_cnt), 32'd1);
    check("ovf_after_t3", 0, 32'(overflow), 32'd1);
    hold_done = 1'b0;
    wait_rx(10, 200);
    for (int i = 0; i < 20; i++) tick();
    send_pix(PKT, 3);
    wait_rx(11, 200);

    // 4: frame edge in the middle of a packet
    frame_edge();
    send_pix(PKT, 3);
    send_pix(5, 3);
    frame_edge();
    send_pix(PKT, 3);
    wait_rx(13, 400);
    for (int i = 0; i < 10; i++) tick();

    // 5: one-cycle reset while the payload is streaming
    begin
      int k = 0;
      frame_edge();
      send_pix(PKT, 1);
      while (!(in_pkt && wcnt >= NH + 3) && k < 200) begin
        tick();
        k++;
      end
      check("reach_mid_pay", 0, 32'(in_pkt && wcnt >= NH + 3), 32'd1);
      rst_n = 1'b0;
      tick();
      check_outputs_zero("midpay_reset");
      rst_n = 1'b1;
      tick();
    end
    frame_edge();
    send_pix(PKT, 3);
    wait_rx(14, 400);
    for (int i = 0; i < 10; i++) tick();

    for (int i = 0; i < NEXP; i++) begin
      check("pkt_present", i, 32'(i < n_rx), 32'd1);
      if (i < n_rx) begin
        check("tx_len", i, 32'(rx_len[i]), 32'(EXP_LEN));
        check("first_pix", i, 32'(rx_first[i]), 32'(exp_tab[i].first));
        check("contiguous", i, 32'(rx_contig[i]), 32'd1);
`ifdef VID_SCHED_HDR_EN
        check("hdr_frame_id", i, 32'(rx_h0[i]), 32'(exp_tab[i].fid));
        check("hdr_pkt_idx", i, 32'(rx_h1[i]), 32'(exp_tab[i].pid));
`endif
      end
    end
    check("rx_count", 0, 32'(n_rx), 32'(NEXP));
    check("start_count", 0, 32'(n_start), 32'(NEXP + 1));
    check("extra_words", 0, 32'(extra_words), 32'd0);
    check("drop_final", 0, 32'(drop_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
